ram: RTL and testbench



---
 rtl/ram_if.sv | 34 +++
 rtl/ram.sv | 62 ++++++
 tb/tb_ram.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ram_if.sv
// EX/MEM -> MEM/WB pipeline bus for the data-memory stage.
// The master drives the EX/MEM fields and the slave returns the MEM/WB fields.
interface ram_if;
    logic        ExMem_Jump;
    logic        ExMem_Branch;
    logic        ExMem_MemRead;
    logic        ExMem_MemtoReg;
    logic        ExMem_MemWrite;
    logic        ExMem_RegWrite;
    logic [4:0]  ExMem_AluOut;
    logic [4:0]  ExMem_AddrRdRt;
    logic [31:0] ExMem_DataRt;
    logic [4:0]  MemWb_AluOut;
    logic [31:0] MemWb_ReadData;
    logic [4:0]  MemWb_AddrRdRt;
    logic        MemWb_MemtoReg;
    logic        MemWb_RegWrite;

    modport master (
        output ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg,
               ExMem_MemWrite, ExMem_RegWrite, ExMem_AluOut, ExMem_AddrRdRt,
               ExMem_DataRt,
        input  MemWb_AluOut, MemWb_ReadData, MemWb_AddrRdRt, MemWb_MemtoReg,
               MemWb_RegWrite
    );

    modport slave (
        input  ExMem_Jump, ExMem_Branch, ExMem_MemRead, ExMem_MemtoReg,
               ExMem_MemWrite, ExMem_RegWrite, ExMem_AluOut, ExMem_AddrRdRt,
               ExMem_DataRt,
        output MemWb_AluOut, MemWb_ReadData, MemWb_AddrRdRt, MemWb_MemtoReg,
               MemWb_RegWrite
    );
endinterface

// File: rtl/ram.sv
// MEM stage: 32 x 32-bit data RAM plus the MEM/WB pipeline register.
// Define RAM_WRITE_BYPASS_EN for write-first data on a same-cycle load+store.
module ram (
    input  logic   CLK,
    input  logic   RST_N,
    ram_if.slave   bus
);
    logic [31:0] mem_r [0:31];
    logic [31:0] read_data_s;
    logic        unused_s;

    // Jump/Branch travel in the EX/MEM register but are consumed by PC logic.
    assign unused_s = bus.ExMem_Jump ^ bus.ExMem_Branch;

    // Load data for this cycle; zero when no load is requested.
    always_comb begin
        read_data_s = 32'd0;
        if (bus.ExMem_MemRead) begin
`ifdef RAM_WRITE_BYPASS_EN
            if (bus.ExMem_MemWrite) begin
                read_data_s = bus.ExMem_DataRt;
            end else begin
                read_data_s = mem_r[bus.ExMem_AluOut];
            end
`else
            read_data_s = mem_r[bus.ExMem_AluOut];
`endif
        end else begin
            read_data_s = 32'd0;
        end
    end

    // Memory array: reset clears every word, otherwise stores update one word.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (bus.ExMem_MemWrite) begin
            mem_r[bus.ExMem_AluOut] <= bus.ExMem_DataRt;
        end else begin
            mem_r[bus.ExMem_AluOut] <= mem_r[bus.ExMem_AluOut];
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.MemWb_AluOut   <= 5'd0;
            bus.MemWb_ReadData <= 32'd0;
            bus.MemWb_AddrRdRt <= 5'd0;
            bus.MemWb_MemtoReg <= 1'b0;
            bus.MemWb_RegWrite <= 1'b0;
        end else begin
            bus.MemWb_AluOut   <= bus.ExMem_AluOut;
            bus.MemWb_ReadData <= read_data_s;
            bus.MemWb_AddrRdRt <= bus.ExMem_AddrRdRt;
            bus.MemWb_MemtoReg <= bus.ExMem_MemtoReg;
            bus.MemWb_RegWrite <= bus.ExMem_RegWrite;
        end
    end
endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for the MEM stage data RAM.
// Honours RAM_WRITE_BYPASS_EN for the same-cycle load+store expectation.
module tb_ram;
    logic CLK;
    logic RST_N;
    int   total_r;
    int   bad_r;
    logic [31:0] rw_exp_s;

    ram_if bus ();

    ram dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic cyc(input logic rst, input logic rd, input logic wr,
                       input logic [4:0] addr, input logic [31:0] data,
                       input logic [4:0] rdrt, input logic m2r, input logic rw,
                       input logic jmp, input logic br);
        RST_N              = rst;
        bus.ExMem_MemRead  = rd;
        bus.ExMem_MemWrite = wr;
        bus.ExMem_AluOut   = addr;
        bus.ExMem_DataRt   = data;
        bus.ExMem_AddrRdRt = rdrt;
        bus.ExMem_MemtoReg = m2r;
        bus.ExMem_RegWrite = rw;
        bus.ExMem_Jump     = jmp;
        bus.ExMem_Branch   = br;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total_r++;
        assert (obs === exp) else begin
            bad_r++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total_r = 0;
        bad_r   = 0;
`ifdef RAM_WRITE_BYPASS_EN
        rw_exp_s = 32'h0000_0022;
`else
        rw_exp_s = 32'h0000_0011;
`endif
        // Reset with a pending store and live pass-through fields.
        cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'd7, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_aluout",   {27'd0, bus.MemWb_AluOut},   32'd0);
        check("rst_readdata", bus.MemWb_ReadData,          32'd0);
        check("rst_addrrdrt", {27'd0, bus.MemWb_AddrRdRt}, 32'd0);
        check("rst_memtoreg", {31'd0, bus.MemWb_MemtoReg}, 32'd0);
        check("rst_regwrite", {31'd0, bus.MemWb_RegWrite}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 5'd3, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_store_dropped", bus.MemWb_ReadData,       32'd0);
        check("load3_aluout",      {27'd0, bus.MemWb_AluOut}, 32'd3);

        // Store / load sequence.
        cyc(1'b1, 1'b0, 1'b1, 5'd9,  32'd65, 5'd23, 1'b0, 1'b1, 1'b0, 1'b0);
        check("st9_readdata", bus.MemWb_ReadData,          32'd0);
        check("st9_addrrdrt", {27'd0, bus.MemWb_AddrRdRt}, 32'd23);
        cyc(1'b1, 1'b0, 1'b1, 5'd29, 32'd34, 5'd23, 1'b0, 1'b1, 1'b0, 1'b0);
        check("st29_regwrite", {31'd0, bus.MemWb_RegWrite}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 5'd29, 32'd0, 5'd23, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ld29", bus.MemWb_ReadData, 32'd34);
        check("ld29_addrrdrt", {27'd0, bus.MemWb_AddrRdRt}, 32'd23);
        cyc(1'b1, 1'b1, 1'b0, 5'd9,  32'd0, 5'd23, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ld9", bus.MemWb_ReadData, 32'd65);
        check("ld9_regwrite", {31'd0, bus.MemWb_RegWrite}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 5'd25, 32'd0, 5'd23, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ld25_unwritten", bus.MemWb_ReadData, 32'd0);
        check("ld25_aluout", {27'd0, bus.MemWb_AluOut}, 32'd25);

        // Pass-through with no load: read data must be zero.
        cyc(1'b1, 1'b0, 1'b0, 5'd17, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pt_aluout",   {27'd0, bus.MemWb_AluOut},   32'd17);
        check("pt_addrrdrt", {27'd0, bus.MemWb_AddrRdRt}, 32'd5);
        check("pt_memtoreg", {31'd0, bus.MemWb_MemtoReg}, 32'd1);
        check("pt_regwrite", {31'd0, bus.MemWb_RegWrite}, 32'd0);
        check("pt_readdata", bus.MemWb_ReadData,          32'd0);

        // Same-cycle load and store to one address.
        cyc(1'b1, 1'b0, 1'b1, 5'd4, 32'h11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 5'd4, 32'h22, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rw_same_cycle", bus.MemWb_ReadData, rw_exp_s);
        cyc(1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rw_after", bus.MemWb_ReadData, 32'h22);

        // Reset mid-stream clears stored data.
        cyc(1'b1, 1'b0, 1'b1, 5'd31, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 5'd31, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ld31_before_rst", bus.MemWb_ReadData, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, 1'b0, 5'd31, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_readdata", bus.MemWb_ReadData, 32'd0);
        check("midrst_addrrdrt", {27'd0, bus.MemWb_AddrRdRt}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 5'd31, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ld31_after_rst", bus.MemWb_ReadData, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ld9_after_rst", bus.MemWb_ReadData, 32'd0);

        // Jump/Branch toggling must not disturb a store or load.
        cyc(1'b1, 1'b0, 1'b1, 5'd2, 32'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5'd2, 32'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ld2_jmp_br", bus.MemWb_ReadData, 32'd5);

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end
endmodule
